// File: rtl/pipeline_hazard_ctrl.sv
// Front-end pipeline sequencer: load-use stall, vector-op EXE hold, branch squash,
// plus a saturating count of cycles in which the PC was held.
module pipeline_hazard_ctrl #(
  parameter int VEC_CYCLES   = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_AW       = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_use_src1,
  input  logic              id_use_src2,
  input  logic              id_is_vec,
  input  logic [REG_AW-1:0] exe_dir_dest,
  input  logic              exe_mem_rd,
  input  logic              exe_reg_wr,
  input  logic              branch_taken,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_exe_en,
  output logic              id_exe_bubble,
  output logic              exe_busy,
  output logic [15:0]       stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_VEC_BUSY = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0] VEC_LOAD   = 4'(VEC_CYCLES - 1);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic [15:0] stall_cnt_r;
  logic        haz_s;
  logic        pc_en_s, if_id_en_s, if_id_flush_s, id_exe_en_s, id_exe_bubble_s, exe_busy_s;

  assign haz_s = id_valid & exe_mem_rd & exe_reg_wr &
                 ((id_use_src1 & (id_src1 == exe_dir_dest)) |
                  (id_use_src2 & (id_src2 == exe_dir_dest)));

  // State and sequencing counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and output decode; branch beats hazard beats vector issue
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    pc_en_s         = 1'b1;
    if_id_en_s      = 1'b1;
    if_id_flush_s   = 1'b0;
    id_exe_en_s     = 1'b1;
    id_exe_bubble_s = 1'b0;
    exe_busy_s      = 1'b0;
    if (!rst_n) begin
      state_nxt_s     = ST_RUN;
      cnt_nxt_s       = 4'd0;
      pc_en_s         = 1'b0;
      if_id_en_s      = 1'b0;
      id_exe_en_s     = 1'b0;
      if_id_flush_s   = 1'b1;
      id_exe_bubble_s = 1'b1;
    end else if (branch_taken) begin
      if_id_flush_s   = 1'b1;
      id_exe_bubble_s = 1'b1;
      if (FLUSH_CYCLES == 0) begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = 4'd0;
      end else begin
        state_nxt_s = ST_FLUSH;
        cnt_nxt_s   = FLUSH_LOAD;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          if (haz_s) begin
            pc_en_s         = 1'b0;
            if_id_en_s      = 1'b0;
            id_exe_bubble_s = 1'b1;
          end else if (id_valid && id_is_vec && (VEC_CYCLES > 1)) begin
            state_nxt_s = ST_VEC_BUSY;
            cnt_nxt_s   = VEC_LOAD;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_VEC_BUSY: begin
          pc_en_s     = 1'b0;
          if_id_en_s  = 1'b0;
          id_exe_en_s = 1'b0;
          exe_busy_s  = 1'b1;
          cnt_nxt_s   = cnt_r - 4'd1;
          // <=1 rather than ==1 so a corrupted zero count cannot lock the front end
          if (cnt_r <= 4'd1) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_VEC_BUSY;
          end
        end
        ST_FLUSH: begin
          id_exe_bubble_s = 1'b1;
          cnt_nxt_s       = cnt_r - 4'd1;
          if (cnt_r <= 4'd1) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_FLUSH;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 4'd0;
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 16'd0;
    end else if (!pc_en_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign pc_en         = pc_en_s;
  assign if_id_en      = if_id_en_s;
  assign if_id_flush   = if_id_flush_s;
  assign id_exe_en     = id_exe_en_s;
  assign id_exe_bubble = id_exe_bubble_s;
  assign exe_busy      = exe_busy_s;
  assign stall_cnt     = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with default parameters (VEC_CYCLES=4, FLUSH_CYCLES=1).
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_src1, id_use_src2, id_is_vec;
  logic [2:0]  id_src1, id_src2, exe_dir_dest;
  logic        exe_mem_rd, exe_reg_wr, branch_taken;
  logic        pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_bubble, exe_busy;
  logic [15:0] stall_cnt;
  int          tests = 0;
  int          fails = 0;

  // Output bundle order: {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_bubble, exe_busy}
  localparam logic [5:0] O_RUN = 6'b110100;
  localparam logic [5:0] O_RST = 6'b001010;
  localparam logic [5:0] O_HAZ = 6'b000110;
  localparam logic [5:0] O_BR  = 6'b111110;
  localparam logic [5:0] O_VB  = 6'b000001;
  localparam logic [5:0] O_FL  = 6'b110110;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_is_vec(id_is_vec),
    .exe_dir_dest(exe_dir_dest), .exe_mem_rd(exe_mem_rd), .exe_reg_wr(exe_reg_wr),
    .branch_taken(branch_taken),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_exe_en(id_exe_en), .id_exe_bubble(id_exe_bubble), .exe_busy(exe_busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_bubble, exe_busy};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: outputs observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] exp);
    tests++;
    assert (stall_cnt === exp) else begin
      fails++;
      $error("FAIL %s: stall_cnt observed %0d expected %0d", tag, stall_cnt, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change at edge+1, checks at edge+3
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_src1 = 3'd0; id_src2 = 3'd0;
    id_use_src1 = 1'b0; id_use_src2 = 1'b0; id_is_vec = 1'b0;
    exe_dir_dest = 3'd0; exe_mem_rd = 1'b0; exe_reg_wr = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    check_out("reset_outputs", O_RST);
    check_cnt("reset_cnt", 16'd0);
    step(); step();
    rst_n = 1'b1;
    #2;
    check_out("run_idle", O_RUN);
    check_cnt("run_idle_cnt", 16'd0);

    // 1: load-use on src1
    step();
    id_valid = 1'b1; id_src1 = 3'd3; id_use_src1 = 1'b1;
    exe_mem_rd = 1'b1; exe_reg_wr = 1'b1; exe_dir_dest = 3'd3;
    #2 check_out("haz_src1", O_HAZ);
    step();
    exe_mem_rd = 1'b0; exe_reg_wr = 1'b0;
    #2 check_out("haz_released", O_RUN);
    check_cnt("haz_cnt", 16'd1);

    // 2: near-miss cases
    exe_mem_rd = 1'b1; exe_reg_wr = 1'b1; id_use_src1 = 1'b0;
    #1 check_out("no_use_src1", O_RUN);
    id_use_src1 = 1'b1; exe_dir_dest = 3'd4;
    #1 check_out("dest_mismatch", O_RUN);
    exe_dir_dest = 3'd3; exe_reg_wr = 1'b0;
    #1 check_out("no_reg_wr", O_RUN);
    exe_reg_wr = 1'b1; id_use_src1 = 1'b0; id_use_src2 = 1'b1; id_src2 = 3'd5; exe_dir_dest = 3'd5;
    #1 check_out("haz_src2", O_HAZ);
    step();
    idle();
    #2 check_cnt("haz_src2_cnt", 16'd2);

    // 3: vector op holds EXE for 3 extra cycles; hazard ignored while busy
    id_valid = 1'b1; id_is_vec = 1'b1;
    #2 check_out("vec_issue", O_RUN);
    step(); idle();
    #2 check_out("vec_busy1", O_VB);
    step();
    id_valid = 1'b1; id_src1 = 3'd2; id_use_src1 = 1'b1;
    exe_mem_rd = 1'b1; exe_reg_wr = 1'b1; exe_dir_dest = 3'd2;
    #2 check_out("vec_busy2_haz_ignored", O_VB);
    step(); idle();
    #2 check_out("vec_busy3", O_VB);
    step();
    #2 check_out("vec_done", O_RUN);
    check_cnt("vec_cnt", 16'd5);

    // 4: branch in the 2nd busy cycle aborts the vector op
    id_valid = 1'b1; id_is_vec = 1'b1;
    step(); idle();
    #2 check_out("vec2_busy1", O_VB);
    step();
    branch_taken = 1'b1;
    #2 check_out("branch_in_vec", O_BR);
    step(); branch_taken = 1'b0;
    #2 check_out("flush_after_vec", O_FL);
    step();
    #2 check_out("run_after_flush", O_RUN);
    check_cnt("branch_vec_cnt", 16'd6);

    // 5: branch beats hazard; branch in FLUSH reloads the bubble
    id_valid = 1'b1; id_src1 = 3'd1; id_use_src1 = 1'b1;
    exe_mem_rd = 1'b1; exe_reg_wr = 1'b1; exe_dir_dest = 3'd1; branch_taken = 1'b1;
    #2 check_out("branch_over_haz", O_BR);
    step(); idle(); branch_taken = 1'b1;
    #2 check_out("branch_in_flush", O_BR);
    step(); branch_taken = 1'b0;
    #2 check_out("flush_reloaded", O_FL);
    step();
    #2 check_out("run_after_reload", O_RUN);
    check_cnt("branch_cnt", 16'd6);

    // 6: asynchronous reset in the middle of a vector hold
    id_valid = 1'b1; id_is_vec = 1'b1;
    step(); idle();
    #2 check_out("vec3_busy1", O_VB);
    rst_n = 1'b0;
    #1 check_out("async_reset_outputs", O_RST);
    check_cnt("async_reset_cnt", 16'd0);
    step();
    rst_n = 1'b1;
    #2 check_out("after_reset_run", O_RUN);
    check_cnt("after_reset_cnt", 16'd0);
    step();
    #2 check_out("after_reset_still_run", O_RUN);
    check_cnt("after_reset_cnt2", 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
